mcu_fetch_responder: RTL and testbench

MCU_FETCH_RESPONDER -- requirements
Module: mcu_fetch_responder

---
 rtl/mcu_fetch_responder.sv | 179 +++++++++++++++++
 tb/tb_mcu_fetch_responder.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcu_fetch_responder.sv
// Instruction-fetch responder: locks the core counter, issues one memory read, and holds the result until the decoder takes it.
// Optional build macro MCU_FETCH_TIMEOUT_EN adds a WAIT-state timeout that drops into the sticky ERROR state.
module mcu_fetch_responder #(
    parameter int unsigned TIMEOUT_CYC   = 15,
    parameter bit          REDIRECT_PRIO = 1'b1
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic [31:0] i_address_from_cpu,
    input  logic        i_address_valid,
    output logic [7:0]  o_address_to_cpu,
    output logic        o_cpu_set_enable,
    output logic        o_lock_cpu,
    output logic        o_mem_req,
    output logic [31:0] o_mem_addr,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata,
    output logic [31:0] o_instr,
    output logic        o_instr_valid,
    input  logic        i_instr_ready,
    input  logic        i_redirect_valid,
    input  logic [7:0]  i_redirect_addr,
    output logic        o_fetch_error
);

    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 15) begin : g_bad_timeout
        $error("TIMEOUT_CYC must lie in 1..15");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_HOLD,
        S_ERROR
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  addr_q, addr_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;
    logic        lock_q, lock_d;
    logic        set_en_q, set_en_d;
    logic [7:0]  tgt_q, tgt_d;
    logic        pend_q, pend_d;
    logic [7:0]  pend_addr_q, pend_addr_d;
    logic        discard_q, discard_d;
`ifdef MCU_FETCH_TIMEOUT_EN
    localparam logic [3:0] TIMEOUT_LAST = 4'(TIMEOUT_CYC - 1);
    logic [3:0]  cnt_q, cnt_d;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            instr_q     <= '0;
            valid_q     <= 1'b0;
            lock_q      <= 1'b0;
            set_en_q    <= 1'b0;
            tgt_q       <= '0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            discard_q   <= 1'b0;
`ifdef MCU_FETCH_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            instr_q     <= instr_d;
            valid_q     <= valid_d;
            lock_q      <= lock_d;
            set_en_q    <= set_en_d;
            tgt_q       <= tgt_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
            discard_q   <= discard_d;
`ifdef MCU_FETCH_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    // NOTE: every _d gets a default before the case so no path leaves a latch behind.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        instr_d     = instr_q;
        valid_d     = valid_q;
        lock_d      = lock_q;
        set_en_d    = 1'b0;
        tgt_d       = tgt_q;
        pend_d      = pend_q;
        pend_addr_d = pend_addr_q;
        discard_d   = discard_q;
`ifdef MCU_FETCH_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (i_redirect_valid || pend_q) begin
                    set_en_d = 1'b1;
                    tgt_d    = i_redirect_valid ? i_redirect_addr : pend_addr_q;
                    pend_d   = 1'b0;
                end else if (i_address_valid) begin
                    addr_d  = i_address_from_cpu[7:0];
                    lock_d  = 1'b1;
                    state_d = (|i_address_from_cpu[31:8]) ? S_ERROR : S_ISSUE;
                end
            end
            S_ISSUE, S_WAIT: begin
                if (i_redirect_valid) begin
                    if (REDIRECT_PRIO) begin
                        set_en_d  = 1'b1;
                        tgt_d     = i_redirect_addr;
                        discard_d = 1'b1;
                    end else begin
                        pend_d      = 1'b1;
                        pend_addr_d = i_redirect_addr;
                    end
                end
                // An ack in ISSUE is stray and ignored; discard_d covers a redirect arriving with the ack.
                if (state_q == S_ISSUE) begin
                    state_d = S_WAIT;
`ifdef MCU_FETCH_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end else if (i_mem_ack) begin
                    if (discard_d) begin
                        state_d   = S_IDLE;
                        lock_d    = 1'b0;
                        discard_d = 1'b0;
                    end else begin
                        instr_d = i_mem_rdata;
                        valid_d = 1'b1;
                        state_d = S_HOLD;
                    end
                end
`ifdef MCU_FETCH_TIMEOUT_EN
                else if (cnt_q == TIMEOUT_LAST) begin
                    state_d   = S_ERROR;
                    discard_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
`endif
            end
            S_HOLD: begin
                if (i_instr_ready || (i_redirect_valid && REDIRECT_PRIO)) begin
                    valid_d = 1'b0;
                    lock_d  = 1'b0;
                    state_d = S_IDLE;
                    pend_d  = 1'b0;
                    if (i_redirect_valid || pend_q) begin
                        set_en_d = 1'b1;
                        tgt_d    = i_redirect_valid ? i_redirect_addr : pend_addr_q;
                    end
                end else if (i_redirect_valid) begin
                    pend_d      = 1'b1;
                    pend_addr_d = i_redirect_addr;
                end
            end
            S_ERROR: lock_d = 1'b1;
            default: state_d = S_IDLE;
        endcase
    end

    assign o_address_to_cpu = tgt_q;
    assign o_cpu_set_enable = set_en_q;
    assign o_lock_cpu       = lock_q;
    assign o_mem_req        = (state_q == S_ISSUE);
    assign o_mem_addr       = {22'b0, addr_q, 2'b00};
    assign o_instr          = instr_q;
    assign o_instr_valid    = valid_q;
    assign o_fetch_error    = (state_q == S_ERROR);

endmodule

// File: tb/tb_mcu_fetch_responder.sv
// Directed bench for mcu_fetch_responder: u_p1 aborts on redirect (REDIRECT_PRIO=1, TIMEOUT_CYC=3), u_p0 defers (REDIRECT_PRIO=0).
module tb_mcu_fetch_responder;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic [31:0] addr = '0;
    logic        addr_valid = 1'b0;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        ready = 1'b0;
    logic        redir_v = 1'b0;
    logic [7:0]  redir_a = '0;

    logic [7:0]  p1_addr_cpu, p0_addr_cpu;
    logic        p1_set_en, p0_set_en, p1_lock, p0_lock, p1_req, p0_req;
    logic [31:0] p1_maddr, p0_maddr, p1_instr, p0_instr;
    logic        p1_ivalid, p0_ivalid, p1_err, p0_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mcu_fetch_responder #(.TIMEOUT_CYC(3), .REDIRECT_PRIO(1'b1)) u_p1 (
        .clk(clk), .n_rst(n_rst), .i_address_from_cpu(addr), .i_address_valid(addr_valid),
        .o_address_to_cpu(p1_addr_cpu), .o_cpu_set_enable(p1_set_en), .o_lock_cpu(p1_lock),
        .o_mem_req(p1_req), .o_mem_addr(p1_maddr), .i_mem_ack(mem_ack), .i_mem_rdata(mem_rdata),
        .o_instr(p1_instr), .o_instr_valid(p1_ivalid), .i_instr_ready(ready),
        .i_redirect_valid(redir_v), .i_redirect_addr(redir_a), .o_fetch_error(p1_err)
    );

    mcu_fetch_responder #(.REDIRECT_PRIO(1'b0)) u_p0 (
        .clk(clk), .n_rst(n_rst), .i_address_from_cpu(addr), .i_address_valid(addr_valid),
        .o_address_to_cpu(p0_addr_cpu), .o_cpu_set_enable(p0_set_en), .o_lock_cpu(p0_lock),
        .o_mem_req(p0_req), .o_mem_addr(p0_maddr), .i_mem_ack(mem_ack), .i_mem_rdata(mem_rdata),
        .o_instr(p0_instr), .o_instr_valid(p0_ivalid), .i_instr_ready(ready),
        .i_redirect_valid(redir_v), .i_redirect_addr(redir_a), .o_fetch_error(p0_err)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        addr = '0; addr_valid = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
        ready = 1'b0; redir_v = 1'b0; redir_a = '0;
    endtask

    task automatic do_reset();
        cyc();
        clear_inputs();
        n_rst = 1'b0;
        cyc();
        n_rst = 1'b1;
    endtask

    // Leaves both DUTs in their first WAIT cycle.
    task automatic start_fetch(input logic [31:0] a);
        addr = a; addr_valid = 1'b1;
        cyc();
        addr_valid = 1'b0;
        cyc();
    endtask

    task automatic test_reset();
        cyc();
        n_rst = 1'b0;
        #2;
        checks++; if ({p1_addr_cpu, p1_set_en, p1_lock, p1_req, p1_maddr, p1_instr, p1_ivalid, p1_err} !== '0) begin errors++; $display("FAIL reset_p1_outputs: got nonzero set_en=%b lock=%b req=%b err=%b", p1_set_en, p1_lock, p1_req, p1_err); end
        checks++; if ({p0_addr_cpu, p0_set_en, p0_lock, p0_req, p0_maddr, p0_instr, p0_ivalid, p0_err} !== '0) begin errors++; $display("FAIL reset_p0_outputs: got nonzero set_en=%b lock=%b req=%b err=%b", p0_set_en, p0_lock, p0_req, p0_err); end
        cyc();
        n_rst = 1'b1;
    endtask

    task automatic test_basic_fetch();
        do_reset();
        addr = 32'h0000_0005; addr_valid = 1'b1;
        cyc();
        addr_valid = 1'b0;
        checks++; if (p1_req !== 1'b1) begin errors++; $display("FAIL basic_req: got %b exp 1", p1_req); end
        checks++; if (p1_maddr !== 32'h14) begin errors++; $display("FAIL basic_maddr: got %h exp 00000014", p1_maddr); end
        checks++; if (p1_lock !== 1'b1) begin errors++; $display("FAIL basic_lock: got %b exp 1", p1_lock); end
        cyc();
        checks++; if (p1_req !== 1'b0) begin errors++; $display("FAIL basic_req_one_cycle: got %b exp 0", p1_req); end
        cyc();
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        cyc();
        mem_ack = 1'b0; mem_rdata = '0;
        checks++; if (p1_ivalid !== 1'b1 || p1_instr !== 32'hDEAD_BEEF) begin errors++; $display("FAIL basic_instr_p1: got v=%b %h exp v=1 deadbeef", p1_ivalid, p1_instr); end
        checks++; if (p0_ivalid !== 1'b1 || p0_instr !== 32'hDEAD_BEEF) begin errors++; $display("FAIL basic_instr_p0: got v=%b %h exp v=1 deadbeef", p0_ivalid, p0_instr); end
        cyc();
        checks++; if (p1_ivalid !== 1'b1 || p1_instr !== 32'hDEAD_BEEF) begin errors++; $display("FAIL basic_hold_stable: got v=%b %h exp v=1 deadbeef", p1_ivalid, p1_instr); end
        ready = 1'b1;
        cyc();
        ready = 1'b0;
        checks++; if (p1_ivalid !== 1'b0 || p1_lock !== 1'b0) begin errors++; $display("FAIL basic_release: got v=%b lock=%b exp 0 0", p1_ivalid, p1_lock); end
    endtask

    // Constant valid/ack/ready: four-cycle turnaround, and acks in ISSUE/IDLE must be ignored.
    task automatic test_back_to_back();
        logic [7:0] exp_req, exp_v, exp_l;
        exp_req = 8'b1000_1000;
        exp_v   = 8'b0010_0010;
        exp_l   = 8'b1110_1110;
        do_reset();
        addr = 32'h0000_002A; addr_valid = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hCAFE_0001; ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cyc();
            checks++; if ({p1_req, p1_ivalid, p1_lock} !== {exp_req[7-i], exp_v[7-i], exp_l[7-i]}) begin errors++; $display("FAIL b2b_cycle%0d: got req/v/lock=%b%b%b exp %b%b%b", i, p1_req, p1_ivalid, p1_lock, exp_req[7-i], exp_v[7-i], exp_l[7-i]); end
        end
        checks++; if (p1_maddr !== 32'hA8) begin errors++; $display("FAIL b2b_maddr: got %h exp 000000a8", p1_maddr); end
        clear_inputs();
    endtask

    task automatic test_idle_redirect();
        do_reset();
        addr = 32'h0000_0009; addr_valid = 1'b1; redir_v = 1'b1; redir_a = 8'h33;
        cyc();
        redir_v = 1'b0;
        checks++; if (p1_set_en !== 1'b1 || p1_addr_cpu !== 8'h33) begin errors++; $display("FAIL idle_redir_p1: got en=%b %h exp 1 33", p1_set_en, p1_addr_cpu); end
        checks++; if (p0_set_en !== 1'b1 || p0_addr_cpu !== 8'h33) begin errors++; $display("FAIL idle_redir_p0: got en=%b %h exp 1 33", p0_set_en, p0_addr_cpu); end
        checks++; if (p1_req !== 1'b0 || p1_lock !== 1'b0) begin errors++; $display("FAIL idle_redir_nofetch: got req=%b lock=%b exp 0 0", p1_req, p1_lock); end
        cyc();
        addr_valid = 1'b0;
        checks++; if (p1_set_en !== 1'b0 || p1_req !== 1'b1) begin errors++; $display("FAIL idle_redir_after: got en=%b req=%b exp 0 1", p1_set_en, p1_req); end
    endtask

    task automatic test_wait_redirect();
        do_reset();
        start_fetch(32'h0000_0007);
        redir_v = 1'b1; redir_a = 8'h40;
        cyc();
        redir_v = 1'b0;
        checks++; if (p1_set_en !== 1'b1 || p1_addr_cpu !== 8'h40) begin errors++; $display("FAIL wait_redir_strobe: got en=%b %h exp 1 40", p1_set_en, p1_addr_cpu); end
        checks++; if (p0_set_en !== 1'b0) begin errors++; $display("FAIL wait_redir_p0_defer: got en=%b exp 0", p0_set_en); end
        cyc();
        checks++; if (p1_set_en !== 1'b0) begin errors++; $display("FAIL wait_redir_one_cycle: got en=%b exp 0", p1_set_en); end
        mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
        cyc();
        mem_ack = 1'b0;
        checks++; if (p1_ivalid !== 1'b0 || p1_lock !== 1'b0) begin errors++; $display("FAIL wait_redir_discard: got v=%b lock=%b exp 0 0", p1_ivalid, p1_lock); end
        checks++; if (p0_ivalid !== 1'b1 || p0_instr !== 32'h1234_5678) begin errors++; $display("FAIL wait_redir_p0_data: got v=%b %h exp 1 12345678", p0_ivalid, p0_instr); end
        ready = 1'b1;
        cyc();
        ready = 1'b0;
        checks++; if (p0_set_en !== 1'b1 || p0_addr_cpu !== 8'h40 || p0_ivalid !== 1'b0) begin errors++; $display("FAIL wait_redir_p0_exit: got en=%b %h v=%b exp 1 40 0", p0_set_en, p0_addr_cpu, p0_ivalid); end
        checks++; if (p1_set_en !== 1'b0 || p1_ivalid !== 1'b0) begin errors++; $display("FAIL wait_redir_p1_quiet: got en=%b v=%b exp 0 0", p1_set_en, p1_ivalid); end
        cyc();
        checks++; if (p0_set_en !== 1'b0) begin errors++; $display("FAIL wait_redir_p0_one_cycle: got en=%b exp 0", p0_set_en); end
    endtask

    task automatic test_pending_overwrite();
        do_reset();
        start_fetch(32'h0000_0011);
        redir_v = 1'b1; redir_a = 8'h10;
        cyc();
        redir_a = 8'h20;
        cyc();
        redir_v = 1'b0;
        checks++; if (p0_set_en !== 1'b0) begin errors++; $display("FAIL pend_no_early_strobe: got en=%b exp 0", p0_set_en); end
        checks++; if (p1_set_en !== 1'b1 || p1_addr_cpu !== 8'h20) begin errors++; $display("FAIL pend_p1_second: got en=%b %h exp 1 20", p1_set_en, p1_addr_cpu); end
        mem_ack = 1'b1; mem_rdata = 32'h0000_00AA;
        cyc();
        mem_ack = 1'b0;
        checks++; if (p0_ivalid !== 1'b1 || p0_set_en !== 1'b0) begin errors++; $display("FAIL pend_hold: got v=%b en=%b exp 1 0", p0_ivalid, p0_set_en); end
        ready = 1'b1;
        cyc();
        ready = 1'b0;
        checks++; if (p0_set_en !== 1'b1 || p0_addr_cpu !== 8'h20) begin errors++; $display("FAIL pend_exit_strobe: got en=%b %h exp 1 20", p0_set_en, p0_addr_cpu); end
        cyc();
        checks++; if (p0_set_en !== 1'b0) begin errors++; $display("FAIL pend_single_strobe: got en=%b exp 0", p0_set_en); end
    endtask

    task automatic test_hold_redirect();
        do_reset();
        start_fetch(32'h0000_0022);
        mem_ack = 1'b1; mem_rdata = 32'hA5A5_A5A5;
        cyc();
        mem_ack = 1'b0;
        redir_v = 1'b1; redir_a = 8'h55;
        cyc();
        redir_v = 1'b0;
        checks++; if (p1_ivalid !== 1'b0 || p1_set_en !== 1'b1 || p1_addr_cpu !== 8'h55 || p1_lock !== 1'b0) begin errors++; $display("FAIL hold_redir_p1: got v=%b en=%b %h lock=%b exp 0 1 55 0", p1_ivalid, p1_set_en, p1_addr_cpu, p1_lock); end
        checks++; if (p0_ivalid !== 1'b1 || p0_set_en !== 1'b0) begin errors++; $display("FAIL hold_redir_p0_keep: got v=%b en=%b exp 1 0", p0_ivalid, p0_set_en); end
        ready = 1'b1;
        cyc();
        ready = 1'b0;
        checks++; if (p0_set_en !== 1'b1 || p0_addr_cpu !== 8'h55 || p0_ivalid !== 1'b0) begin errors++; $display("FAIL hold_redir_p0_exit: got en=%b %h v=%b exp 1 55 0", p0_set_en, p0_addr_cpu, p0_ivalid); end
        start_fetch(32'h0000_0023);
        mem_ack = 1'b1; mem_rdata = 32'h0BAD_F00D;
        cyc();
        mem_ack = 1'b0;
        checks++; if (p1_ivalid !== 1'b1 || p0_ivalid !== 1'b1) begin errors++; $display("FAIL hold_same_setup: got v1=%b v0=%b exp 1 1", p1_ivalid, p0_ivalid); end
        redir_v = 1'b1; redir_a = 8'h66; ready = 1'b1;
        cyc();
        redir_v = 1'b0; ready = 1'b0;
        checks++; if (p0_ivalid !== 1'b0 || p0_set_en !== 1'b1 || p0_addr_cpu !== 8'h66 || p0_lock !== 1'b0) begin errors++; $display("FAIL hold_same_p0: got v=%b en=%b %h lock=%b exp 0 1 66 0", p0_ivalid, p0_set_en, p0_addr_cpu, p0_lock); end
        checks++; if (p1_set_en !== 1'b1 || p1_addr_cpu !== 8'h66) begin errors++; $display("FAIL hold_same_p1: got en=%b %h exp 1 66", p1_set_en, p1_addr_cpu); end
    endtask

    task automatic test_addr_error();
        int bad;
        do_reset();
        addr = 32'h0000_0100; addr_valid = 1'b1;
        cyc();
        checks++; if (p1_err !== 1'b1 || p1_lock !== 1'b1 || p1_req !== 1'b0) begin errors++; $display("FAIL err_enter: got err=%b lock=%b req=%b exp 1 1 0", p1_err, p1_lock, p1_req); end
        addr = 32'h0000_0005; mem_ack = 1'b1; ready = 1'b1; redir_v = 1'b1; redir_a = 8'h77;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            if (p1_err !== 1'b1 || p1_req !== 1'b0 || p1_set_en !== 1'b0 || p0_err !== 1'b1) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL err_sticky: got %0d bad cycles exp 0", bad); end
        do_reset();
        checks++; if (p1_err !== 1'b0 || p1_lock !== 1'b0) begin errors++; $display("FAIL err_reset_clears: got err=%b lock=%b exp 0 0", p1_err, p1_lock); end
    endtask

    task automatic test_timeout();
        int bad;
        do_reset();
        start_fetch(32'h0000_0030);
`ifdef MCU_FETCH_TIMEOUT_EN
        cyc();
        cyc();
        checks++; if (p1_err !== 1'b0) begin errors++; $display("FAIL timeout_early: got err=%b exp 0", p1_err); end
        cyc();
        checks++; if (p1_err !== 1'b1 || p1_lock !== 1'b1) begin errors++; $display("FAIL timeout_fire: got err=%b lock=%b exp 1 1", p1_err, p1_lock); end
        checks++; if (p0_err !== 1'b0) begin errors++; $display("FAIL timeout_p0_not_yet: got err=%b exp 0", p0_err); end
`else
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            cyc();
            if (p1_err !== 1'b0 || p1_lock !== 1'b1 || p1_req !== 1'b0 || p1_ivalid !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL wait_forever: got %0d bad cycles exp 0", bad); end
        mem_ack = 1'b1; mem_rdata = 32'h0000_0BEE;
        cyc();
        mem_ack = 1'b0;
        checks++; if (p1_ivalid !== 1'b1 || p1_instr !== 32'h0000_0BEE) begin errors++; $display("FAIL wait_late_ack: got v=%b %h exp 1 00000bee", p1_ivalid, p1_instr); end
`endif
    endtask

    task automatic test_reset_mid_fetch();
        do_reset();
        start_fetch(32'h0000_0044);
        n_rst = 1'b0;
        #2;
        checks++; if ({p1_addr_cpu, p1_set_en, p1_lock, p1_req, p1_maddr, p1_instr, p1_ivalid, p1_err} !== '0) begin errors++; $display("FAIL midreset_async: got lock=%b req=%b maddr=%h", p1_lock, p1_req, p1_maddr); end
        cyc();
        n_rst = 1'b1;
        mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        cyc();
        mem_ack = 1'b0;
        checks++; if (p1_ivalid !== 1'b0 || p1_lock !== 1'b0 || p1_req !== 1'b0 || p1_instr !== 32'h0) begin errors++; $display("FAIL midreset_ack_ignored: got v=%b lock=%b req=%b instr=%h exp 0 0 0 0", p1_ivalid, p1_lock, p1_req, p1_instr); end
        addr = 32'h0000_0001; addr_valid = 1'b1;
        cyc();
        addr_valid = 1'b0;
        checks++; if (p1_req !== 1'b1 || p1_maddr !== 32'h4) begin errors++; $display("FAIL midreset_idle: got req=%b maddr=%h exp 1 00000004", p1_req, p1_maddr); end
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_back_to_back();
        test_idle_redirect();
        test_wait_redirect();
        test_pending_overwrite();
        test_hold_redirect();
        test_addr_error();
        test_timeout();
        test_reset_mid_fetch();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
